// File: rtl/pa_toeplitz_hash_core_if.sv
// Handshake bundle for the Toeplitz hash core: control, random/key streams and hash output.
interface pa_toeplitz_hash_core_if #(
  parameter int unsigned PA_W = 64,
  parameter int unsigned PA_K = 1024
);
  logic            start;
  logic            busy;
  logic [PA_W-1:0] rnd_data;
  logic            rnd_valid;
  logic            rnd_ready;
  logic [PA_W-1:0] key_data;
  logic            key_valid;
  logic            key_ready;
  logic [PA_K-1:0] hash;
  logic            hash_valid;
  logic            hash_ready;

  modport master (
    output start, rnd_data, rnd_valid, key_data, key_valid, hash_ready,
    input  busy, rnd_ready, key_ready, hash, hash_valid
  );

  modport slave (
    input  start, rnd_data, rnd_valid, key_data, key_valid, hash_ready,
    output busy, rnd_ready, key_ready, hash, hash_valid
  );
endinterface

// File: rtl/pa_toeplitz_hash_core.sv
// Toeplitz hash core: preloads a seed window from the random stream, then folds
// N_KEY key words into a PA_K-bit accumulator using a sliding seed window.
module pa_toeplitz_hash_core #(
  parameter int unsigned PA_W  = 64,
  parameter int unsigned PA_K  = 1024,
  parameter int unsigned N_KEY = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pa_toeplitz_hash_core_if.slave bus
);
  localparam int unsigned S   = PA_K / PA_W + 1;
  localparam int unsigned RW  = S * PA_W;
  localparam int unsigned PCW = $clog2(S + 1);
  localparam int unsigned KCW = $clog2(N_KEY + 1);

  typedef enum logic [1:0] {IDLE, PRELOAD, HASH, DONE} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   r_q, r_d;
  logic [PCW-1:0]  pcnt_q, pcnt_d;
  logic [KCW-1:0]  kcnt_q, kcnt_d;
  logic [PA_K-1:0] hash_q, hash_d, hash_upd;
  logic            rnd_ready_c, key_ready_c;

  // Per-bit parity of the seed window against the key; window i is R[i+PA_W:i+1].
  always_comb begin
    hash_upd = '0;
    for (int unsigned i = 0; i < PA_K; i++) begin
      hash_upd[PA_K-1-i] = ^(r_q[i+1 +: PA_W] & bus.key_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      pcnt_q  <= '0;
      kcnt_q  <= '0;
      hash_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      pcnt_q  <= pcnt_d;
      kcnt_q  <= kcnt_d;
      hash_q  <= hash_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    pcnt_d      = pcnt_q;
    kcnt_d      = kcnt_q;
    hash_d      = hash_q;
    rnd_ready_c = 1'b0;
    key_ready_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          hash_d  = '0;
          pcnt_d  = '0;
          kcnt_d  = '0;
          state_d = PRELOAD;
        end
      end
      PRELOAD: begin
        rnd_ready_c = 1'b1;
        if (bus.rnd_valid) begin
          r_d    = {r_q[RW-PA_W-1:0], bus.rnd_data};
          pcnt_d = pcnt_q + PCW'(1);
          if (pcnt_q == PCW'(S - 1)) state_d = HASH;
        end
      end
      HASH: begin
        // A beat needs both streams; neither word is consumed alone.
        rnd_ready_c = bus.key_valid;
        key_ready_c = bus.rnd_valid;
        if (bus.rnd_valid && bus.key_valid) begin
          hash_d = hash_q ^ hash_upd;
          r_d    = {r_q[RW-PA_W-1:0], bus.rnd_data};
          kcnt_d = kcnt_q + KCW'(1);
          if (kcnt_q == KCW'(N_KEY - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.hash_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.hash_valid = (state_q == DONE);
  assign bus.hash       = hash_q;
  assign bus.rnd_ready  = rnd_ready_c;
  assign bus.key_ready  = key_ready_c;
endmodule

// File: doc/pa_toeplitz_hash_core.md
PA_TOEPLITZ_HASH_CORE -- requirements
Module: pa_toeplitz_hash_core

Interface
REQ-001 Parameter PA_W, 64, random/key word width in bits.
REQ-002 Parameter PA_K, 1024, hash output length in bits; PA_K SHALL be a multiple of PA_W and at least PA_W.
REQ-003 Parameter N_KEY, 16, number of key words per hash block; N_KEY SHALL be at least 1.
REQ-004 Derived constant S = PA_K/PA_W + 1; seed register R width is S*PA_W.
REQ-005 Clock and reset are fixed:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Control ports:
- start  in  1  one-cycle request to begin a block; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
REQ-007 Random stream: rnd_data in PA_W; rnd_valid in 1; rnd_ready out 1.
REQ-008 Key stream: key_data in PA_W; key_valid in 1; key_ready out 1.
REQ-009 Hash output: hash out PA_K; hash_valid out 1; hash_ready in 1.

Function
REQ-010 The FSM SHALL have states IDLE, PRELOAD, HASH and DONE.
REQ-011 IDLE with start=1: clear all PA_K accumulator bits and the preload counter, then go to PRELOAD; start in any other state is ignored.
REQ-012 Random-word acceptance and shift:
- rnd_ready = (PRELOAD) or (HASH and key_valid).
- Each accepted random word shifts R: R <= {R[S*PA_W-PA_W-1:0], rnd_data}.
REQ-013 PRELOAD: accept exactly S random words with no accumulation, then go to HASH; the counter is ceil(log2(S+1)) bits.
REQ-014 HASH: key_ready = rnd_valid; a beat occurs only when rnd_valid and key_valid are both 1; a lone valid is not consumed.
REQ-015 On each HASH beat, for every i in 0..PA_K-1:
- hash[PA_K-1-i] <= hash[PA_K-1-i] XOR parity(R[i+PA_W:i+1] AND key_data).
- R is sampled before the same-cycle shift.
REQ-016 The HASH key counter is ceil(log2(N_KEY+1)) bits; after the N_KEY-th beat, go to DONE with no wrap and no extra beat.
REQ-017 DONE:
- hash_valid=1; hash holds stable until the handshake.
- hash_valid and hash_ready both high: go to IDLE next cycle, and hash_valid drops.
REQ-018 Latency is fixed: hash_valid rises exactly one cycle after the last key beat; with continuous valids, start to hash_valid is S+N_KEY+1 cycles.
REQ-019 hash_ready is ignored outside DONE; start together with the DONE handshake is ignored.
REQ-020 The hash output SHALL be registered, with no combinational path from key_data or rnd_data to hash.
REQ-021 Stalls (valid low) in PRELOAD or HASH SHALL freeze R, the counters and the accumulators.

Reset
REQ-022 rst_n=0 asynchronously forces IDLE and clears R, both counters and hash to 0.
REQ-023 During rst_n=0: hash_valid=0, busy=0, rnd_ready=0, key_ready=0.
REQ-024 Reset asserted mid-block aborts the block; no partial hash is ever presented, and the first cycle after deassertion is IDLE.

Verification (PA_W=4, PA_K=8, S=3 unless stated)
REQ-025 Single bit, N_KEY=1:
- start; preload words 4'hF, 4'h0, 4'h0 (R=12'hF00); key 4'h1 with rnd 4'h0.
- Required: hash=8'h01, hash_valid one cycle after the key beat.
REQ-026 Zero key, N_KEY=2:
- Random words all 4'hF, keys 4'h0.
- Required: hash=8'h00, and a second block re-clears.
REQ-027 Backpressure, N_KEY=2:
- key_valid low for 3 cycles mid-HASH while rnd_valid is high.
- Required: no rnd word consumed and hash equals the unstalled run.
- Then hold hash_ready low 5 cycles: hash and hash_valid stable.
REQ-028 Reset mid-HASH:
- rst_n pulsed low after 1 key beat.
- Required: outputs 0 immediately; a fresh block then matches the golden model.
REQ-029 Start outside IDLE:
- start pulsed in PRELOAD, HASH and DONE.
- Required: no effect; the counters and hash match a run with a single start.
REQ-030 Random regression, default parameters:
- 1000 blocks with random valid gaps.
- Required: every hash equals the software Toeplitz model of REQ-015.
